// File: rtl/sort_pkg.sv
// Shared definitions for the insertion sorter and its frame receiver.
// Holds the default frame geometry and the receiver FSM state encoding.
package sort_pkg;

  localparam int SORT_WIDTH = 32;  // data word width
  localparam int SORT_COUNT = 8;   // words per frame (>= 2)
  localparam int SORT_IDX_W = 3;   // clog2(SORT_COUNT)

  // Receiver states; encoding is shared with the sorter side.
  typedef enum logic [1:0] {
    ST_RECV = 2'd0,
    ST_DONE = 2'd1,
    ST_HOLD = 2'd2
  } sort_state_e;

endpackage

// File: rtl/sort_frame_buf.sv
// COUNT x WIDTH register file holding one received frame.
// Ports:
//   clk, reset      clock, async active-low reset (read register only)
//   we/waddr/wdata  single write port
//   re/raddr        read request; rdata valid one cycle after re
//   rdata           registered read data; addresses >= COUNT read as 0
module sort_frame_buf
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH,
  parameter int COUNT = SORT_COUNT,
  parameter int IDX_W = SORT_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  // Frame storage has no reset: contents are meaningless until written.
  logic [WIDTH-1:0] mem_q [COUNT];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read data holds its last value when no read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = (int'(raddr) < COUNT) ? mem_q[raddr] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sorted_frame_rx.sv
// Receive side of the sorter's word stream. Captures one COUNT-word frame
// over a valid/ready handshake, checks on the fly that it is non-decreasing,
// tracks min/max, and holds the frame for random-access readback until ack.
// Ports:
//   clk, reset                 clock, async active-low reset
//   in_valid/in_data/in_ready  input stream handshake (ready only in RECV)
//   ack                        releases the held frame (HOLD only)
//   rd_en/rd_addr              readback request (HOLD only)
//   rd_data/rd_valid           readback response, one cycle later
//   frame_done                 one-cycle pulse when result outputs update
//   order_ok/first_bad         sortedness of held frame, first violating index
//   min_val/max_val            held frame extrema
//   frame_cnt                  completed frames since reset (wraps)
module sorted_frame_rx
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH,
  parameter int COUNT = SORT_COUNT,
  parameter int IDX_W = SORT_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ack,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             frame_done,
  output logic             order_ok,
  output logic [IDX_W-1:0] first_bad,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic [15:0]      frame_cnt
);

  // Write index is one bit wider than an address so it can sit at COUNT
  // after the last word without aliasing back to 0.
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(COUNT - 1);

  sort_state_e      state_q, state_d;
  logic [IDX_W:0]   widx_q, widx_d;

  // Running frame statistics, valid once word 0 has been accepted.
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             run_ok_q, run_ok_d;
  logic [IDX_W-1:0] run_bad_q, run_bad_d;

  // Result registers, loaded once per frame.
  logic             order_ok_q, order_ok_d;
  logic [IDX_W-1:0] first_bad_q, first_bad_d;
  logic [WIDTH-1:0] min_val_q, min_val_d;
  logic [WIDTH-1:0] max_val_q, max_val_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             rd_valid_q, rd_valid_d;

  logic             accept;
  logic             rd_fire;

  assign accept  = in_valid && (state_q == ST_RECV);
  assign rd_fire = rd_en && (state_q == ST_HOLD);

  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    prev_d       = prev_q;
    run_ok_d     = run_ok_q;
    run_bad_d    = run_bad_q;
    order_ok_d   = order_ok_q;
    first_bad_d  = first_bad_q;
    min_val_d    = min_val_q;
    max_val_d    = max_val_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    rd_valid_d   = rd_fire;

    unique case (state_q)
      ST_RECV: begin
        if (accept) begin
          widx_d = widx_q + 1'b1;
          prev_d = in_data;
          if (widx_q == '0) begin
            run_min_d = in_data;
            run_max_d = in_data;
            run_ok_d  = 1'b1;
            run_bad_d = '0;
          end else begin
            if (in_data < run_min_q) run_min_d = in_data;
            if (in_data > run_max_q) run_max_d = in_data;
            // Only the first descent is recorded; equal neighbours are fine.
            if ((in_data < prev_q) && run_ok_q) begin
              run_ok_d  = 1'b0;
              run_bad_d = widx_q[IDX_W-1:0];
            end
          end
          // Results are loaded on the edge into DONE, folding in the last
          // word, so they are already visible while frame_done is high.
          if (widx_q == LAST_IDX) begin
            state_d      = ST_DONE;
            order_ok_d   = run_ok_d;
            first_bad_d  = run_bad_d;
            min_val_d    = run_min_d;
            max_val_d    = run_max_d;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            frame_done_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (ack) begin
          state_d = ST_RECV;
          widx_d  = '0;
        end
      end
      default: state_d = ST_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RECV;
      widx_q       <= '0;
      run_min_q    <= '0;
      run_max_q    <= '0;
      prev_q       <= '0;
      run_ok_q     <= 1'b0;
      run_bad_q    <= '0;
      order_ok_q   <= 1'b0;
      first_bad_q  <= '0;
      min_val_q    <= '0;
      max_val_q    <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      prev_q       <= prev_d;
      run_ok_q     <= run_ok_d;
      run_bad_q    <= run_bad_d;
      order_ok_q   <= order_ok_d;
      first_bad_q  <= first_bad_d;
      min_val_q    <= min_val_d;
      max_val_q    <= max_val_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Reads are gated by HOLD, and HOLD never writes, so an ack in the same
  // cycle as a read still returns the held word.
  sort_frame_buf #(
    .WIDTH(WIDTH),
    .COUNT(COUNT),
    .IDX_W(IDX_W)
  ) u_buf (
    .clk  (clk),
    .reset(reset),
    .we   (accept),
    .waddr(widx_q[IDX_W-1:0]),
    .wdata(in_data),
    .re   (rd_fire),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign in_ready   = (state_q == ST_RECV);
  assign rd_valid   = rd_valid_q;
  assign frame_done = frame_done_q;
  assign order_ok   = order_ok_q;
  assign first_bad  = first_bad_q;
  assign min_val    = min_val_q;
  assign max_val    = max_val_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sorted_frame_rx.sv
// Self-checking bench for sorted_frame_rx: table of directed frames, random
// frames against a reference model, and a mid-frame async reset sequence.
module tb_sorted_frame_rx;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int IW = 3;

  typedef logic [C-1:0][W-1:0] frame_t;

  typedef struct {
    frame_t         w;
    bit             gaps;
    bit             ok;
    logic [IW-1:0]  bad;
    logic [W-1:0]   mn;
    logic [W-1:0]   mx;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          ack;
  logic          rd_en;
  logic [IW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          frame_done;
  logic          order_ok;
  logic [IW-1:0] first_bad;
  logic [W-1:0]  min_val;
  logic [W-1:0]  max_val;
  logic [15:0]   frame_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int exp_cnt = 0;

  sorted_frame_rx #(.WIDTH(W), .COUNT(C), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ack(ack), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done),
    .order_ok(order_ok), .first_bad(first_bad), .min_val(min_val),
    .max_val(max_val), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Reference: scan the finished frame as a whole.
  task automatic model(input frame_t w, output bit ok, output logic [IW-1:0] bad,
                       output logic [W-1:0] mn, output logic [W-1:0] mx);
    bit found;
    mn = w[0]; mx = w[0]; ok = 1'b1; bad = '0; found = 1'b0;
    for (int i = 0; i < C; i++) begin
      if (w[i] < mn) mn = w[i];
      if (w[i] > mx) mx = w[i];
      if (i > 0 && !found && w[i] < w[i-1]) begin
        found = 1'b1; ok = 1'b0; bad = IW'(i);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},   W'(in_ready),   1);
    chk({tag, "_rd_valid"},   W'(rd_valid),   0);
    chk({tag, "_rd_data"},    rd_data,        0);
    chk({tag, "_frame_done"}, W'(frame_done), 0);
    chk({tag, "_order_ok"},   W'(order_ok),   0);
    chk({tag, "_first_bad"},  W'(first_bad),  0);
    chk({tag, "_min_val"},    min_val,        0);
    chk({tag, "_max_val"},    max_val,        0);
    chk({tag, "_frame_cnt"},  W'(frame_cnt),  0);
  endtask

  // Drive one frame; returns at the negedge after the last accepting edge.
  task automatic send_frame(input frame_t w, input bit gaps);
    chk("in_ready_recv", W'(in_ready), 1);
    for (int i = 0; i < C; i++) begin
      int g;
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = w[i];
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input frame_t w, input bit gaps, input bit e_ok,
                           input logic [IW-1:0] e_bad, input logic [W-1:0] e_mn,
                           input logic [W-1:0] e_mx);
    send_frame(w, gaps);
    exp_cnt++;
    // DONE cycle: pulse plus results
    chk("frame_done", W'(frame_done), 1);
    chk("in_ready_done", W'(in_ready), 0);
    chk("order_ok", W'(order_ok), W'(e_ok));
    chk("first_bad", W'(first_bad), W'(e_bad));
    chk("min_val", min_val, e_mn);
    chk("max_val", max_val, e_mx);
    chk("frame_cnt", W'(frame_cnt), W'(exp_cnt[15:0]));
    // Stray beats while not receiving must be dropped.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("frame_done_pulse", W'(frame_done), 0);
    chk("in_ready_hold", W'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    // Back-to-back readback of the whole frame.
    for (int i = 0; i < C; i++) begin
      rd_en   = 1'b1;
      rd_addr = IW'(i);
      @(negedge clk);
      chk("rd_valid", W'(rd_valid), 1);
      chk($sformatf("rd_data[%0d]", i), rd_data, w[i]);
    end
    rd_en = 1'b0;
    @(negedge clk);
    chk("rd_valid_idle", W'(rd_valid), 0);
    chk("order_ok_stable", W'(order_ok), W'(e_ok));
    chk("min_stable", min_val, e_mn);
    // ack together with a read of word 5
    ack = 1'b1; rd_en = 1'b1; rd_addr = 3'd5;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_rd_valid", W'(rd_valid), 1);
    chk("ack_rd_data", rd_data, w[5]);
    chk("ack_in_ready", W'(in_ready), 1);
    chk("ack_keeps_max", max_val, e_mx);
    // read in RECV is ignored
    rd_addr = 3'd0;
    @(negedge clk);
    rd_en = 1'b0;
    chk("recv_rd_valid", W'(rd_valid), 0);
  endtask

  vec_t vecs[6];

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; ack = 1'b0;
    rd_en = 1'b0; rd_addr = '0;

    vecs[0] = '{mk(1, 2, 2, 5, 7, 9, 10, 30), 1'b0, 1'b1, 3'd0, 32'd1, 32'd30};
    vecs[1] = '{mk(3, 4, 1, 8, 2, 9, 9, 0),   1'b0, 1'b0, 3'd2, 32'd0, 32'd9};
    vecs[2] = '{mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
                1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{mk(0, 1, 2, 3, 4, 5, 6, 5),   1'b0, 1'b0, 3'd7, 32'd0, 32'd6};
    vecs[4] = '{mk(1, 2, 2, 5, 7, 9, 10, 30), 1'b1, 1'b1, 3'd0, 32'd1, 32'd30};
    vecs[5] = '{mk(9, 9, 9, 9, 9, 9, 9, 9),   1'b1, 1'b1, 3'd0, 32'd9, 32'd9};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_frame(vecs[i].w, vecs[i].gaps, vecs[i].ok, vecs[i].bad, vecs[i].mn, vecs[i].mx);

    // Random frames against the reference model.
    for (int n = 0; n < 20; n++) begin
      frame_t         w;
      bit             e_ok;
      logic [IW-1:0]  e_bad;
      logic [W-1:0]   e_mn, e_mx;
      int             mode;
      logic [W-1:0]   v;
      mode = int'($urandom_range(0, 2));
      v = $urandom_range(0, 100);
      for (int i = 0; i < C; i++) begin
        case (mode)
          0:       begin w[i] = v; v = v + $urandom_range(0, 3); end
          1:       w[i] = $urandom_range(0, 15);
          default: w[i] = $urandom;
        endcase
      end
      model(w, e_ok, e_bad, e_mn, e_mx);
      run_frame(w, n[0], e_ok, e_bad, e_mn, e_mx);
    end

    // Async reset in the middle of a frame.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd100 + W'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_vals("midreset");
    #1 reset = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    run_frame(mk(8, 7, 6, 5, 4, 3, 2, 1), 1'b0, 1'b0, 3'd1, 32'd1, 32'd8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sorted_frame_rx.md
# sorted_frame_rx

Receive side of the sorter's serial word stream. Accepts one frame of `COUNT` words via a valid/ready handshake and stores it in a local buffer. Checks on the fly that the frame is non-decreasing and reports min, max and the first out-of-order index. Holds the frame for random-access readback until the consumer acknowledges. Sits directly downstream of the insertion-sort block as its checker/consumer.

## Interface
Parameters:
- `WIDTH`, 32: data word width.
- `COUNT`, 8: words per frame; must be ≥2.
- `IDX_W`, 3: index width, equal to clog2(`COUNT`).

Ports:
- `clk` in, 1: single clock; all logic on its rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: `in_data` is valid this cycle.
- `in_data` in, `WIDTH`: stream word, unsigned.
- `in_ready` out, 1: block accepts a word this cycle.
- `ack` in, 1: consumer releases the held frame.
- `rd_en` in, 1: readback request.
- `rd_addr` in, `IDX_W`: readback index.
- `rd_data` out, `WIDTH`: readback word.
- `rd_valid` out, 1: `rd_data` is valid.
- `frame_done` out, 1: one-cycle pulse when frame results are valid.
- `order_ok` out, 1: held frame is non-decreasing.
- `first_bad` out, `IDX_W`: first index i with word[i] < word[i-1]; 0 if `order_ok`.
- `min_val` out, `WIDTH`: held frame minimum.
- `max_val` out, `WIDTH`: held frame maximum.
- `frame_cnt` out, 16: completed frames since reset; wraps from 65535 to 0.

## Operation
- **States:** RECV, DONE, HOLD. Reset enters RECV.
- **RECV:**
  - `in_ready`=1. A beat is accepted when `in_valid`&&`in_ready`.
  - Each accepted word is written to buffer[widx] and widx increments.
  - Word 0 initialises min, max and prev, sets a running ok flag to 1, and clears the bad index.
  - Word i>0 updates min/max with unsigned compares.
  - If word < prev and the flag is still 1, clear the flag and record `first_bad`=i. Only the first violation is recorded.
  - Equal adjacent words are legal.
  - When word `COUNT`-1 is accepted, go to DONE.
- **DONE (1 cycle):**
  - `in_ready`=0.
  - Results are copied to the output registers and `frame_done`=1.
  - `frame_cnt` increments.
  - Go to HOLD.
- **HOLD:**
  - `in_ready`=0.
  - Result outputs are stable.
  - Readback is served.
  - `ack` moves the block to RECV with widx=0.
- **Readback:** `rd_en` is honoured only in HOLD. `rd_addr` ≥ `COUNT` returns 0 with `rd_valid`=1.
- **Ignored inputs:** `ack` is ignored outside HOLD. `in_valid` is ignored outside RECV.
- **Arithmetic:** all compares are unsigned, full `WIDTH`. widx is `IDX_W`+1 bits wide, or compared against `COUNT`-1, so it never wraps mid-frame.

## Timing
- **Reset values:**
  - State=RECV, widx=0.
  - `in_ready`=1 (driven from registered state).
  - `rd_valid`=0, `rd_data`=0, `frame_done`=0.
  - `order_ok`=0, `first_bad`=0, `min_val`=0, `max_val`=0, `frame_cnt`=0.
  - Buffer contents are don't-care.
- **Frame latency:** last accepted beat at cycle N produces `frame_done` at N+1 (DONE). HOLD starts at N+2.
- **Readback latency:** `rd_en` at cycle T gives `rd_data`/`rd_valid` at T+1. `rd_valid` is a one-cycle pulse per request, and back-to-back requests are allowed.
- **`ack` with `rd_en` in the same HOLD cycle:** the read is served at T+1 with the held data, because the buffer is not written until a new beat is accepted. The state is RECV at T+1.
- **Earliest next beat:** the first beat of the next frame can be accepted in the cycle after `ack`.
- **Result registers:** hold their values until the next DONE. They do not clear on `ack`.
- **Reset mid-frame or in HOLD:** the partial frame is discarded, all outputs return to reset values, and the next accepted beat is word 0.
- **Gaps:** `in_valid` gaps within a frame are allowed. Running state persists across the gaps.

## Structure
- **Shared package `sort_pkg`:** `WIDTH`, `COUNT` and `IDX_W` defaults, and the state encoding (RECV=0, DONE=1, HOLD=2). The sorter and this block both import it.
- **Sub-module `sort_frame_buf`:** a `COUNT`×`WIDTH` register file with one write port (we, waddr, wdata) and one synchronous read port (re, raddr, rdata, 1-cycle latency).
- **Top level:** holds the FSM, the running compare logic and the output registers.

## Test plan
- **Sorted frame:** reset, then stream 1,2,2,5,7,9,10,30 with `in_valid` continuous → `frame_done` one cycle after the 8th beat; `order_ok`=1, `first_bad`=0, `min_val`=1, `max_val`=30, `frame_cnt`=1.
- **Unsorted frame:** stream 3,4,1,8,2,9,9,0 → `order_ok`=0, `first_bad`=2, `min_val`=0, `max_val`=9. `in_ready`=0 during DONE and HOLD, and an extra `in_valid` beat in HOLD is not stored.
- **Readback:** in HOLD, `rd_en` addr 0..7 back-to-back → `rd_data` equals the input words one cycle later, with `rd_valid` high for 8 cycles. Additionally, `rd_en` in RECV → `rd_valid`=0.
- **`ack` with read:** assert `ack` and `rd_en`(addr 5) together → the held word 5 appears next cycle and the state is RECV. A second frame of 0xFFFFFFFF ×8 gives `order_ok`=1, `min_val`=`max_val`=0xFFFFFFFF, `frame_cnt`=2.
- **Reset mid-frame:** accept 5 beats, pulse `reset` low asynchronously → all outputs are at reset values immediately. A following full frame 8..1 is received whole: `first_bad`=1, `min_val`=1, `frame_cnt`=1.
- **Gaps:** stream with random `in_valid` gaps of 0–3 cycles → same results as the gap-free case.
